matmul_ctrl_n: RTL and testbench
================================

# matmul_ctrl_n

Parametrised successor to the fixed 2x2 matrix-multiply controller. It holds two N×N operand matrices A and B, loaded element by element over a narrow byte bus, and computes C = A·B on a single time-shared MAC. Results are returned one element per request, with selectable signed/unsigned arithmetic and optional saturation. It sits between the chip-level pin wrapper and nothing else; the wrapper maps pins onto these ports.

## Interface
Parameters:
- N, 2: matrix dimension; legal range 2..4.
- DW, 8: operand and output element width, in bits.
- IW, $clog2(N*N): element index width.
- ACC_W, 2*DW+$clog2(N): accumulator and C-element width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  write in_data into the operand selected by load_sel_ab.
- load_sel_ab  in  1  0 = A, 1 = B.
- load_index  in  IW  element index, row-major: index = row*N + col.
- in_data  in  DW  operand element.
- start  in  1  begin computation.
- signed_mode  in  1  1 = operands are two's complement; 0 = unsigned.
- sat_en  in  1  1 = saturate the output element to DW bits; 0 = return the low DW bits.
- output_en  in  1  request element C[output_sel].
- output_sel  in  IW  result index, row-major.
- out_data  out  DW  registered result byte.
- busy  out  1  high while computing.
- done  out  1  high once a result is valid.

## Operation
- States:
  - IDLE → COMPUTE: start sampled high.
  - COMPUTE → DONE: after the last MAC cycle.
  - DONE → COMPUTE: start.
  - DONE → IDLE: load_en.
- Loads:
  - Accepted in IDLE and DONE; ignored in COMPUTE.
  - load_index ≥ N*N is ignored.
  - A load in DONE clears done. The C contents are retained.
- Compute loop:
  - Counters i (row), j (col), k (inner), nested k-fastest. N³ cycles total.
  - Each cycle: acc_next = (k==0 ? 0 : acc) + ext(A[i][k])·ext(B[k][j]).
  - ext sign-extends operands when signed_mode=1 and zero-extends them when signed_mode=0, to ACC_W bits.
  - When k==N-1, C[i][j] is written with acc_next.
  - signed_mode and sat_en are sampled when start is accepted and held for the whole run.
- Output (when output_en is high), out_data is set as follows:
  - output_sel ≥ N*N → 0.
  - sat_en=0 → C[sel][DW-1:0].
  - sat_en=1, signed → C clamped to [-2^(DW-1), 2^(DW-1)-1].
  - sat_en=1, unsigned → C clamped to [0, 2^DW-1].
  - output_en is serviced in every state. During COMPUTE it returns the current C contents, which may be partly stale.
- start while in COMPUTE is ignored.
- start and load_en in the same IDLE cycle: the load is written, and compute starts the next cycle using the new value.

## Timing
- Reset sets:
  - State IDLE; busy=0, done=0, out_data=0.
  - All A, B and C storage, the counters and acc cleared to 0.
- Reset mid-COMPUTE aborts the run; the next cycle is IDLE with all storage zero.
- Operand writes are visible the cycle after load_en.
- Start latency:
  - start is sampled at edge t.
  - busy rises at t+1 and stays high for exactly N³ cycles.
  - done rises in the cycle busy falls (t+1+N³). busy and done are never high together.
- done remains high until start, load_en or rst.
- Output latency: out_data updates one cycle after output_en and holds its value while output_en is low.
- Mode and saturation are applied using the modes latched at start.

## Test plan
- N=2, DW=8, unsigned, sat_en=0. Load A=[[1,2],[3,4]] and B=[[5,6],[7,8]], then pulse start.
  - busy is high for 8 cycles, then done=1.
  - Reading indices 0..3 returns 19, 22, 43, 50.
- Signed mode. Load A=[[-1,2],[3,-4]] and B=[[5,6],[7,8]].
  - C = 9, 10, -13, -14.
  - Out bytes are 0x09, 0x0A, 0xF3, 0xF2.
- Saturation. Set every element of A and B to 100, so each C = 20000 (0x4E20).
  - sat_en=0 → 0x20.
  - Signed with sat → 0x7F. Unsigned with sat → 0xFF.
  - Signed operands -100 and 100 with sat → 0x80.
- Protocol.
  - load_en during busy does not change A or B (check by re-running the compute).
  - start during busy does not restart the run: busy stays exactly N³ cycles.
  - A load in DONE drops done the next cycle while C reads remain unchanged.
  - output_sel=N*N returns 0.
- Reset mid-compute. Assert rst at cycle 3 of COMPUTE.
  - Next cycle: busy=0, done=0, out_data=0.
  - A subsequent start with no loads gives every C = 0.
- N=3 build. Load A = identity and B = values 1..9.
  - busy lasts 27 cycles.
  - C reads back 1..9.

Source files
------------

// File: rtl/matmul_ctrl_n_if.sv
// Handshake/bus bundle for matmul_ctrl_n: operand loading, compute control and result readback.
interface matmul_ctrl_n_if #(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int IW = $clog2(N*N)
) ();
  logic          load_en;
  logic          load_sel_ab;
  logic [IW-1:0] load_index;
  logic [DW-1:0] in_data;
  logic          start;
  logic          signed_mode;
  logic          sat_en;
  logic          output_en;
  logic [IW-1:0] output_sel;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;

  modport master (
    output load_en, load_sel_ab, load_index, in_data, start,
           signed_mode, sat_en, output_en, output_sel,
    input  out_data, busy, done
  );

  modport slave (
    input  load_en, load_sel_ab, load_index, in_data, start,
           signed_mode, sat_en, output_en, output_sel,
    output out_data, busy, done
  );
endinterface

// File: rtl/matmul_ctrl_n.sv
// NxN matrix-multiply controller: byte-wide operand loads, one time-shared MAC
// computing C = A*B in N^3 cycles, and per-element readback with optional saturation.
module matmul_ctrl_n #(
  parameter int N     = 2,
  parameter int DW    = 8,
  parameter int IW    = $clog2(N*N),
  parameter int ACC_W = 2*DW + $clog2(N)
) (
  input logic            clk,
  input logic            rst,
  matmul_ctrl_n_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam int NE = N*N;
  localparam logic [CW-1:0]          LAST = CW'(N-1);
  localparam logic [IW:0]            NE_W = (IW+1)'(NE);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DW-1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic [ACC_W-1:0]        UMAX = ACC_W'((1 << DW) - 1);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t state, state_next;

  logic [DW-1:0]    a_mem [NE];
  logic [DW-1:0]    b_mem [NE];
  logic [ACC_W-1:0] c_mem [NE];

  logic [CW-1:0]    i_cnt, j_cnt, k_cnt;
  logic [ACC_W-1:0] acc, acc_next, a_ext, b_ext, c_val;
  logic [IW-1:0]    a_idx, b_idx, c_idx;
  logic [DW-1:0]    out_next;
  logic             signed_q, sat_q;
  logic             last_mac, load_ok, start_ok;

  assign last_mac = (i_cnt == LAST) && (j_cnt == LAST) && (k_cnt == LAST);
  assign load_ok  = bus.load_en && (state != COMPUTE) && ({1'b0, bus.load_index} < NE_W);
  assign start_ok = bus.start && (state != COMPUTE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = COMPUTE;
      COMPUTE: if (last_mac)  state_next = DONE;
      DONE: begin
        if (bus.start)        state_next = COMPUTE;
        else if (bus.load_en) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == COMPUTE);
    bus.done = (state == DONE);
  end

  always_comb begin
    a_idx = IW'(int'(i_cnt) * N + int'(k_cnt));
    b_idx = IW'(int'(k_cnt) * N + int'(j_cnt));
    c_idx = IW'(int'(i_cnt) * N + int'(j_cnt));
    a_ext = signed_q ? {{(ACC_W-DW){a_mem[a_idx][DW-1]}}, a_mem[a_idx]}
                     : {{(ACC_W-DW){1'b0}}, a_mem[a_idx]};
    b_ext = signed_q ? {{(ACC_W-DW){b_mem[b_idx][DW-1]}}, b_mem[b_idx]}
                     : {{(ACC_W-DW){1'b0}}, b_mem[b_idx]};
    // Truncated modular product is exact for both signednesses at ACC_W bits.
    acc_next = ((k_cnt == '0) ? '0 : acc) + a_ext * b_ext;
  end

  always_comb begin
    c_val = '0;
    if ({1'b0, bus.output_sel} < NE_W) c_val = c_mem[bus.output_sel];
    out_next = c_val[DW-1:0];
    if (sat_q) begin
      if (signed_q) begin
        if ($signed(c_val) > SMAX)      out_next = {1'b0, {(DW-1){1'b1}}};
        else if ($signed(c_val) < SMIN) out_next = {1'b1, {(DW-1){1'b0}}};
      end else if (c_val > UMAX) begin
        out_next = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand and result arrays are reset explicitly; a mid-run abort must leave all storage zero.
      for (int e = 0; e < NE; e++) begin
        a_mem[e] <= '0;
        b_mem[e] <= '0;
        c_mem[e] <= '0;
      end
      i_cnt        <= '0;
      j_cnt        <= '0;
      k_cnt        <= '0;
      acc          <= '0;
      signed_q     <= 1'b0;
      sat_q        <= 1'b0;
      bus.out_data <= '0;
    end else begin
      if (load_ok) begin
        if (bus.load_sel_ab) b_mem[bus.load_index] <= bus.in_data;
        else                 a_mem[bus.load_index] <= bus.in_data;
      end
      if (start_ok) begin
        i_cnt    <= '0;
        j_cnt    <= '0;
        k_cnt    <= '0;
        signed_q <= bus.signed_mode;
        sat_q    <= bus.sat_en;
      end else if (state == COMPUTE) begin
        acc <= acc_next;
        if (k_cnt == LAST) begin
          c_mem[c_idx] <= acc_next;
          k_cnt        <= '0;
          if (j_cnt == LAST) begin
            j_cnt <= '0;
            i_cnt <= i_cnt + 1'b1;
          end else begin
            j_cnt <= j_cnt + 1'b1;
          end
        end else begin
          k_cnt <= k_cnt + 1'b1;
        end
      end
      if (bus.output_en) bus.out_data <= out_next;
    end
  end

endmodule

// File: tb/tb_matmul_ctrl_n.sv
// Directed bench for matmul_ctrl_n: an N=2 and an N=3 instance driven from one linear sequence.
module tb_matmul_ctrl_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   cyc;
  int   overlap = 0;
  logic [7:0] rd;
  logic [7:0] exp_basic  [4] = '{8'd19, 8'd22, 8'd43, 8'd50};
  logic [7:0] exp_signed [4] = '{8'h09, 8'h0A, 8'hF3, 8'hF2};

  always #5 clk = ~clk;

  matmul_ctrl_n_if #(.N(2)) bus2 ();
  matmul_ctrl_n_if #(.N(3)) bus3 ();

  matmul_ctrl_n #(.N(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
  matmul_ctrl_n #(.N(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load2(input logic ab, input logic [1:0] idx, input logic [7:0] d);
    bus2.load_en = 1'b1; bus2.load_sel_ab = ab; bus2.load_index = idx; bus2.in_data = d;
    tick();
    bus2.load_en = 1'b0;
  endtask

  task automatic load3(input logic ab, input logic [3:0] idx, input logic [7:0] d);
    bus3.load_en = 1'b1; bus3.load_sel_ab = ab; bus3.load_index = idx; bus3.in_data = d;
    tick();
    bus3.load_en = 1'b0;
  endtask

  // Pulses start, then counts cycles with busy high; poke drives a load and a
  // second start in the third busy cycle, both of which must be ignored.
  task automatic run2(input bit poke, output int n);
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    n = 0;
    while (bus2.busy && n < 100) begin
      n++;
      if (bus2.done) overlap++;
      if (poke && n == 3) begin
        bus2.load_en = 1'b1; bus2.load_sel_ab = 1'b0; bus2.load_index = 2'd0;
        bus2.in_data = 8'd7; bus2.start = 1'b1;
      end
      tick();
      bus2.load_en = 1'b0;
      bus2.start   = 1'b0;
    end
  endtask

  task automatic run3(output int n);
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    n = 0;
    while (bus3.busy && n < 200) begin
      n++;
      if (bus3.done) overlap++;
      tick();
    end
  endtask

  task automatic read2(input logic [1:0] s, output logic [7:0] d);
    bus2.output_en = 1'b1; bus2.output_sel = s;
    tick();
    bus2.output_en = 1'b0;
    d = bus2.out_data;
  endtask

  task automatic read3(input logic [3:0] s, output logic [7:0] d);
    bus3.output_en = 1'b1; bus3.output_sel = s;
    tick();
    bus3.output_en = 1'b0;
    d = bus3.out_data;
  endtask

  initial begin
    bus2.load_en = 0; bus2.load_sel_ab = 0; bus2.load_index = '0; bus2.in_data = '0;
    bus2.start = 0; bus2.signed_mode = 0; bus2.sat_en = 0; bus2.output_en = 0; bus2.output_sel = '0;
    bus3.load_en = 0; bus3.load_sel_ab = 0; bus3.load_index = '0; bus3.in_data = '0;
    bus3.start = 0; bus3.signed_mode = 0; bus3.sat_en = 0; bus3.output_en = 0; bus3.output_sel = '0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset_busy", bus2.busy, 0);
    check("reset_done", bus2.done, 0);
    check("reset_out",  bus2.out_data, 0);
    check("reset3_busy", bus3.busy, 0);

    // Unsigned, no saturation: A=[[1,2],[3,4]], B=[[5,6],[7,8]]
    for (int e = 0; e < 4; e++) begin
      load2(1'b0, 2'(e), 8'(e + 1));
      load2(1'b1, 2'(e), 8'(e + 5));
    end
    run2(1'b0, cyc);
    check("basic_busy_len", cyc, 8);
    check("basic_done", bus2.done, 1);
    for (int e = 0; e < 4; e++) begin
      read2(2'(e), rd);
      check($sformatf("basic_c%0d", e), rd, exp_basic[e]);
    end
    tick(); tick();
    check("out_hold", bus2.out_data, 8'd50);

    // Load in DONE drops done; C retained
    load2(1'b0, 2'd0, 8'hFF);
    check("done_cleared", bus2.done, 0);
    check("idle_not_busy", bus2.busy, 0);
    read2(2'd0, rd);
    check("c_retained", rd, 8'd19);

    // Signed: A=[[-1,2],[3,-4]]; mid-run load and start must be ignored
    load2(1'b0, 2'd3, 8'hFC);
    bus2.signed_mode = 1'b1;
    run2(1'b1, cyc);
    check("signed_busy_len_with_restart", cyc, 8);
    for (int e = 0; e < 4; e++) begin
      read2(2'(e), rd);
      check($sformatf("signed_c%0d", e), rd, exp_signed[e]);
    end
    run2(1'b0, cyc);
    read2(2'd0, rd);
    check("busy_load_ignored_c0", rd, 8'h09);
    read2(2'd1, rd);
    check("busy_load_ignored_c1", rd, 8'h0A);

    // Saturation: all elements 100 -> C = 20000
    for (int e = 0; e < 4; e++) begin
      load2(1'b0, 2'(e), 8'd100);
      load2(1'b1, 2'(e), 8'd100);
    end
    bus2.signed_mode = 1'b0; bus2.sat_en = 1'b0;
    run2(1'b0, cyc);
    read2(2'd0, rd);
    check("wrap_low_byte", rd, 8'h20);
    bus2.signed_mode = 1'b1; bus2.sat_en = 1'b1;
    run2(1'b0, cyc);
    read2(2'd1, rd);
    check("sat_signed_pos", rd, 8'h7F);
    bus2.signed_mode = 1'b0; bus2.sat_en = 1'b0;
    read2(2'd2, rd);
    check("modes_latched", rd, 8'h7F);
    bus2.sat_en = 1'b1;
    run2(1'b0, cyc);
    read2(2'd3, rd);
    check("sat_unsigned", rd, 8'hFF);
    for (int e = 0; e < 4; e++) load2(1'b0, 2'(e), 8'h9C);
    bus2.signed_mode = 1'b1;
    run2(1'b0, cyc);
    read2(2'd3, rd);
    check("sat_signed_neg", rd, 8'h80);

    // Reset in the third COMPUTE cycle
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    tick(); tick();
    check("busy_before_abort", bus2.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", bus2.busy, 0);
    check("abort_done", bus2.done, 0);
    check("abort_out",  bus2.out_data, 0);
    bus2.signed_mode = 1'b0; bus2.sat_en = 1'b0;
    run2(1'b0, cyc);
    check("post_abort_busy_len", cyc, 8);
    for (int e = 0; e < 4; e++) begin
      read2(2'(e), rd);
      check($sformatf("post_abort_c%0d", e), rd, 0);
    end

    // N=3: A = identity, B = 1..9
    for (int e = 0; e < 9; e++) begin
      if (e % 4 == 0) load3(1'b0, 4'(e), 8'd1);
      load3(1'b1, 4'(e), 8'(e + 1));
    end
    run3(cyc);
    check("n3_busy_len", cyc, 27);
    check("n3_done", bus3.done, 1);
    for (int e = 0; e < 9; e++) begin
      read3(4'(e), rd);
      check($sformatf("n3_c%0d", e), rd, 8'(e + 1));
    end
    read3(4'd9, rd);
    check("n3_sel_out_of_range", rd, 0);

    check("busy_done_overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
